// File: rtl/hazard_pkg.sv
// Shared types and bounds for the load-use / branch hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_e;

  localparam int REG_ZERO         = 0;
  localparam int LOAD_LATENCY_MAX = 4;
  localparam int FLUSH_DEPTH_MAX  = 3;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hazard_sat_counter.sv
// Saturating up-counter: holds at all-ones, clears on synchronous reset.
module hazard_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_stall_controller.sv
// Load-use stall / taken-branch flush arbiter beside the ID stage.
// Define HAZARD_PERF_CNT_EN to add saturating stall/flush cycle counters.
module hazard_stall_controller
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W   = 5,
  parameter int LOAD_LATENCY = 1,
  parameter int FLUSH_DEPTH  = 1,
  parameter int CNT_W        = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  branch_taken,
  input  logic                  id_ex_mem_read,
  input  logic [REG_ADDR_W-1:0] id_ex_rt,
  input  logic [REG_ADDR_W-1:0] if_id_rs,
  input  logic [REG_ADDR_W-1:0] if_id_rt,
  input  logic                  if_id_rt_used,
  output logic                  stall,
  output logic                  flush,
  output logic                  busy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_cycles
`endif
);

  localparam int CW = $clog2(max_int(LOAD_LATENCY, FLUSH_DEPTH)) + 1;
  localparam logic [CW-1:0] STALL_RELOAD = CW'(LOAD_LATENCY - 1);
  localparam logic [CW-1:0] FLUSH_RELOAD = CW'(FLUSH_DEPTH - 1);
  localparam logic [CW-1:0] CNT_ONE      = CW'(1);

  if (LOAD_LATENCY < 1 || LOAD_LATENCY > LOAD_LATENCY_MAX) begin : g_bad_load_latency
    $error("LOAD_LATENCY out of range 1..%0d", LOAD_LATENCY_MAX);
  end
  if (FLUSH_DEPTH < 1 || FLUSH_DEPTH > FLUSH_DEPTH_MAX) begin : g_bad_flush_depth
    $error("FLUSH_DEPTH out of range 1..%0d", FLUSH_DEPTH_MAX);
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("CNT_W must be at least 1");
  end

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          hazard;

  assign hazard = id_ex_mem_read
               && (id_ex_rt != REG_ADDR_W'(REG_ZERO))
               && ((id_ex_rt == if_id_rs) || (if_id_rt_used && (id_ex_rt == if_id_rt)));

  // First stall/flush cycle comes straight from the inputs; the tail is counted out.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    flush   = 1'b0;
    unique case (state_q)
      IDLE, STALL: begin
        if (branch_taken) begin
          flush = 1'b1;
          if (FLUSH_DEPTH > 1) begin
            state_d = FLUSH;
            cnt_d   = FLUSH_RELOAD;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end else if (state_q == STALL) begin
          stall = 1'b1;
          if (cnt_q == CNT_ONE) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end else if (hazard) begin
          stall = 1'b1;
          if (LOAD_LATENCY > 1) begin
            state_d = STALL;
            cnt_d   = STALL_RELOAD;
          end
        end
      end
      FLUSH: begin
        flush = 1'b1;
        if (branch_taken) begin
          cnt_d = FLUSH_RELOAD;
        end else if (cnt_q == CNT_ONE) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    if (reset) begin
      stall = 1'b0;
      flush = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = !reset && (state_q != IDLE);

`ifdef HAZARD_PERF_CNT_EN
  hazard_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall),
    .count (stall_cycles)
  );

  hazard_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush),
    .count (flush_cycles)
  );
`endif

endmodule
